// File: rtl/uncache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uncache_ctrl_pkg
//  Description : Shared state encodings and bus access type codes for the
//                uncached access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package uncache_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RREQ  = 3'd1,
        RRESP = 3'd2,
        WREQ  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bus access type codes
    localparam logic [2:0] C_TYPE_BYTE = 3'b000;
    localparam logic [2:0] C_TYPE_HALF = 3'b001;
    localparam logic [2:0] C_TYPE_WORD = 3'b010;

    // Map a pipeline access size onto the bus type code
    function automatic logic [2:0] size_to_type(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uncache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uncache_ctrl_if
//  Description : Pipeline request/response and bus read/write channels of the
//                uncached access controller. The slave modport is the
//                controller's view; master is the surrounding environment
//                (pipeline plus memory bus).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uncache_ctrl_if;

    // Pipeline side
    logic          valid;
    logic          op;
    logic [1:0]    size;
    logic [31:0]   addr;
    logic [3:0]    wstrb;
    logic [31:0]   wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [31:0]   rdata;

    // Bus read request / return
    logic          rd_req;
    logic [2:0]    rd_type;
    logic [31:0]   rd_addr;
    logic          rd_rdy;
    logic          ret_valid;
    logic          ret_last;
    logic [31:0]   ret_data;

    // Bus write channel
    logic          wr_req;
    logic [2:0]    wr_type;
    logic [31:0]   wr_addr;
    logic [3:0]    wr_wstrb;
    logic [127:0]  wr_data;
    logic          wr_rdy;

    modport slave (
        input  valid, op, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata,
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  wr_rdy
    );

    modport master (
        output valid, op, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata,
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output wr_rdy
    );

endinterface
`default_nettype wire

// File: rtl/uncache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uncache_ctrl
//  Description : Single-outstanding uncached access controller. Accepts one
//                pipeline request, issues it as a single bus read or write,
//                and returns a one-cycle data_ok pulse on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module uncache_ctrl
    import uncache_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = IDLE
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uncache_ctrl_if.slave   bus
);

    state_t        r_state;
    logic          r_op;
    logic [1:0]    r_size;
    logic [31:0]   r_addr;
    logic [3:0]    r_wstrb;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_data_ok;
    logic          r_rd_req;
    logic          r_wr_req;

    // Acceptance is the only combinational output: idle and a request present
    assign bus.addr_ok  = (r_state == IDLE) && bus.valid;
    assign bus.data_ok  = r_data_ok;
    assign bus.rdata    = r_rdata;

    // Bus request fields come straight from the latched request, so they
    // cannot move while a request is stalled on rdy
    assign bus.rd_req   = r_rd_req;
    assign bus.rd_type  = size_to_type(r_size);
    assign bus.rd_addr  = r_addr;
    assign bus.wr_req   = r_wr_req;
    assign bus.wr_type  = size_to_type(r_size);
    assign bus.wr_addr  = r_addr;
    assign bus.wr_wstrb = r_wstrb;
    assign bus.wr_data  = {96'b0, r_wdata};

    // Request sequencing FSM; req/data_ok flags are set on entry to the
    // state that owns them and cleared on exit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RESET_STATE;
            r_op      <= 1'b0;
            r_size    <= 2'b00;
            r_addr    <= 32'h0;
            r_wstrb   <= 4'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_data_ok <= 1'b0;
            r_rd_req  <= 1'b0;
            r_wr_req  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.valid) begin
                        r_op    <= bus.op;
                        r_size  <= bus.size;
                        r_addr  <= bus.addr;
                        r_wstrb <= bus.wstrb;
                        r_wdata <= bus.wdata;
                        if (bus.op) begin
                            r_state  <= WREQ;
                            r_wr_req <= 1'b1;
                        end else begin
                            r_state  <= RREQ;
                            r_rd_req <= 1'b1;
                        end
                    end
                end
                RREQ: begin
                    if (bus.rd_rdy) begin
                        r_state  <= RRESP;
                        r_rd_req <= 1'b0;
                    end
                end
                RRESP: begin
                    // Non-final beats carry nothing for a single-word access
                    if (bus.ret_valid && bus.ret_last && !r_op) begin
                        r_rdata   <= bus.ret_data;
                        r_state   <= DONE;
                        r_data_ok <= 1'b1;
                    end
                end
                WREQ: begin
                    if (bus.wr_rdy) begin
                        r_state   <= DONE;
                        r_wr_req  <= 1'b0;
                        r_data_ok <= 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_data_ok <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_data_ok <= 1'b0;
                    r_rd_req  <= 1'b0;
                    r_wr_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uncache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uncache_ctrl
//  Description : Self-checking bench for uncache_ctrl. Directed and random
//                transactions are played against a transaction-level model of
//                expected bus fields, completion timing and returned data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uncache_ctrl;

    typedef struct {
        bit        op;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [3:0]  wstrb;
        bit [31:0] wdata;
        int        delay;    // cycles rdy is held low before the handshake
        int        gap;      // idle cycles before the first return beat
        int        beats;    // number of return beats, last one carries data
        bit [31:0] d0;       // data on non-final beats
        bit [31:0] d1;       // data on the final beat
        bit        overlap;  // present the next request while busy
    } txn_t;

    localparam int N = 30;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_rdata;
    logic        prev_data_ok;
    txn_t        tq [N];

    uncache_ctrl_if ifc ();

    uncache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input txn_t t);
        ifc.valid = 1'b1;
        ifc.op    = t.op;
        ifc.size  = t.size;
        ifc.addr  = t.addr;
        ifc.wstrb = t.wstrb;
        ifc.wdata = t.wdata;
    endtask

    // Bus safety properties observed every cycle
    always @(negedge clk) begin
        check_eq("rd_wr_exclusive", ifc.rd_req & ifc.wr_req, 1'b0);
        check_eq("data_ok_single", prev_data_ok & ifc.data_ok, 1'b0);
        prev_data_ok = ifc.data_ok;
    end

    // Play one transaction; called just after a rising edge with DUT idle
    task automatic do_txn(input txn_t t, input bit has_next, input txn_t nx);
        present(t);
        @(negedge clk);
        check_eq("accept_addr_ok", ifc.addr_ok, 1'b1);
        check_eq("accept_data_ok", ifc.data_ok, 1'b0);
        check_eq("accept_rdata", ifc.rdata, exp_rdata);
        next_cycle();
        if (t.overlap && has_next) present(nx);
        else ifc.valid = 1'b0;

        if (!t.op) begin
            for (int k = 0; k <= t.delay; k++) begin
                ifc.rd_rdy = (k == t.delay);
                @(negedge clk);
                check_eq("rreq_rd_req", ifc.rd_req, 1'b1);
                check_eq("rreq_rd_addr", ifc.rd_addr, t.addr);
                check_eq("rreq_rd_type", ifc.rd_type, {1'b0, t.size});
                check_eq("rreq_busy", {ifc.addr_ok, ifc.data_ok, ifc.wr_req}, 3'b000);
                check_eq("rreq_rdata", ifc.rdata, exp_rdata);
                next_cycle();
            end
            ifc.rd_rdy = 1'b0;
            for (int g = 0; g < t.gap; g++) begin
                @(negedge clk);
                check_eq("rresp_wait", {ifc.addr_ok, ifc.data_ok, ifc.rd_req}, 3'b000);
                next_cycle();
            end
            for (int b = 0; b < t.beats; b++) begin
                ifc.ret_valid = 1'b1;
                ifc.ret_last  = (b == t.beats - 1);
                ifc.ret_data  = (b == t.beats - 1) ? t.d1 : t.d0;
                @(negedge clk);
                check_eq("rresp_beat", {ifc.addr_ok, ifc.data_ok, ifc.rd_req}, 3'b000);
                check_eq("rresp_rdata", ifc.rdata, exp_rdata);
                next_cycle();
            end
            ifc.ret_valid = 1'b0;
            ifc.ret_last  = 1'b0;
            ifc.ret_data  = $urandom;
            exp_rdata     = t.d1;
        end else begin
            for (int k = 0; k <= t.delay; k++) begin
                ifc.wr_rdy = (k == t.delay);
                @(negedge clk);
                check_eq("wreq_wr_req", ifc.wr_req, 1'b1);
                check_eq("wreq_wr_addr", ifc.wr_addr, t.addr);
                check_eq("wreq_wr_type", ifc.wr_type, {1'b0, t.size});
                check_eq("wreq_wr_wstrb", ifc.wr_wstrb, t.wstrb);
                check_eq("wreq_wr_data", ifc.wr_data, {96'b0, t.wdata});
                check_eq("wreq_busy", {ifc.addr_ok, ifc.data_ok, ifc.rd_req}, 3'b000);
                next_cycle();
            end
            ifc.wr_rdy = 1'b0;
        end

        @(negedge clk);
        check_eq("done_data_ok", ifc.data_ok, 1'b1);
        check_eq("done_rdata", ifc.rdata, exp_rdata);
        check_eq("done_quiet", {ifc.addr_ok, ifc.rd_req, ifc.wr_req}, 3'b000);
        next_cycle();
    endtask

    initial begin
        txn_t t_rst;
        txn_t t_wr;
        n_checks     = 0;
        n_errors     = 0;
        exp_rdata    = 32'h0;
        prev_data_ok = 1'b0;
        ifc.valid = 1'b0; ifc.op = 1'b0; ifc.size = 2'b00; ifc.addr = 32'h0;
        ifc.wstrb = 4'h0; ifc.wdata = 32'h0; ifc.rd_rdy = 1'b0; ifc.wr_rdy = 1'b0;
        ifc.ret_valid = 1'b0; ifc.ret_last = 1'b0; ifc.ret_data = 32'h0;

        // Directed: word read, ret one idle cycle after handshake; next request overlaps
        tq[0] = '{op:1'b0, size:2'b10, addr:32'h1faf0004, wstrb:4'h0, wdata:32'h0,
                  delay:0, gap:1, beats:1, d0:32'h0, d1:32'hDEADBEEF, overlap:1'b1};
        // Directed: byte write with wr_rdy low for three cycles
        tq[1] = '{op:1'b1, size:2'b00, addr:32'h1faf0003, wstrb:4'b1000, wdata:32'h55000000,
                  delay:3, gap:0, beats:1, d0:32'h0, d1:32'h0, overlap:1'b0};
        // Directed: two-beat return, only the final beat counts
        tq[2] = '{op:1'b0, size:2'b10, addr:32'h1faf0010, wstrb:4'h0, wdata:32'h0,
                  delay:1, gap:0, beats:2, d0:32'h11111111, d1:32'h22222222, overlap:1'b1};
        // Directed: write with wr_rdy already high
        tq[3] = '{op:1'b1, size:2'b01, addr:32'h1faf0020, wstrb:4'b0011, wdata:32'h0000CAFE,
                  delay:0, gap:0, beats:1, d0:32'h0, d1:32'h0, overlap:1'b0};
        for (int i = 4; i < N; i++) begin
            tq[i].op      = 1'($urandom_range(0, 1));
            tq[i].size    = 2'($urandom_range(0, 2));
            tq[i].addr    = $urandom;
            tq[i].wstrb   = 4'($urandom);
            tq[i].wdata   = $urandom;
            tq[i].delay   = $urandom_range(0, 3);
            tq[i].gap     = $urandom_range(0, 2);
            tq[i].beats   = $urandom_range(1, 3);
            tq[i].d0      = $urandom;
            tq[i].d1      = $urandom;
            tq[i].overlap = 1'($urandom_range(0, 1));
        end

        // Reset state
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("reset_outputs", {ifc.data_ok, ifc.rd_req, ifc.wr_req}, 3'b000);
        check_eq("reset_rdata", ifc.rdata, 32'h0);
        check_eq("reset_rd_addr", ifc.rd_addr, 32'h0);
        check_eq("reset_wr_data", ifc.wr_data, 128'h0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            do_txn(tq[i], (i + 1 < N), tq[(i + 1 < N) ? i + 1 : i]);
        end

        // Reset while waiting for the read return, then a late return beat
        t_rst = tq[0];
        t_rst.addr = 32'h1faf0040;
        present(t_rst);
        @(negedge clk);
        check_eq("rst_seq_accept", ifc.addr_ok, 1'b1);
        next_cycle();
        ifc.valid  = 1'b0;
        ifc.rd_rdy = 1'b1;
        next_cycle();
        ifc.rd_rdy = 1'b0;
        @(negedge clk);
        check_eq("rst_seq_in_rresp", {ifc.rd_req, ifc.data_ok}, 2'b00);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_rdata      = 32'h0;
        ifc.ret_valid  = 1'b1;
        ifc.ret_last   = 1'b1;
        ifc.ret_data   = 32'h12345678;
        @(negedge clk);
        check_eq("late_ret_data_ok", ifc.data_ok, 1'b0);
        check_eq("late_ret_rdata", ifc.rdata, 32'h0);
        next_cycle();
        ifc.ret_valid = 1'b0;
        ifc.ret_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", {ifc.data_ok, ifc.rd_req, ifc.wr_req}, 3'b000);
            check_eq("post_rst_rdata", ifc.rdata, 32'h0);
            next_cycle();
        end
        // Controller must be idle again: a fresh write is accepted at once
        t_wr = tq[3];
        do_txn(t_wr, 1'b0, t_wr);
        @(negedge clk);
        check_eq("final_idle_data_ok", ifc.data_ok, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uncache_ctrl.md
UNCACHE_CTRL -- requirements
Module: uncache_ctrl

Interface
REQ-001 SHALL have parameter RESET_STATE, default IDLE, meaning FSM state after reset; the only legal value is IDLE.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port valid  in  1  pipeline uncached access request.
REQ-005 SHALL have port op  in  1  1=write, 0=read.
REQ-006 SHALL have port size  in  2  00 byte, 01 half, 10 word.
REQ-007 SHALL have port addr  in  32  physical address.
REQ-008 SHALL have port wstrb  in  4  write byte enables.
REQ-009 SHALL have port wdata  in  32  write data.
REQ-010 SHALL have port addr_ok  out  1  request accepted this cycle.
REQ-011 SHALL have port data_ok  out  1  access complete; one-cycle pulse.
REQ-012 SHALL have port rdata  out  32  read data, valid with data_ok for reads.
REQ-013 SHALL have ports rd_req out 1, rd_type out 3, rd_addr out 32, rd_rdy in 1: bus read request channel.
REQ-014 SHALL have ports ret_valid in 1, ret_last in 1, ret_data in 32: bus read return channel.
REQ-015 SHALL have ports wr_req out 1, wr_type out 3, wr_addr out 32, wr_wstrb out 4, wr_data out 128, wr_rdy in 1: bus write channel.

Function
REQ-016 SHALL implement FSM states IDLE, RREQ, RRESP, WREQ, DONE.
REQ-017 addr_ok SHALL equal (state==IDLE && valid), combinationally.
REQ-018 On addr_ok, SHALL register op, size, addr, wstrb, wdata, and go to RREQ (op=0) or WREQ (op=1).
REQ-019 valid while state!=IDLE SHALL be ignored (addr_ok=0); requester holds valid.
REQ-020 In RREQ: rd_req=1, rd_addr=latched addr, rd_type={1'b0,size}; rd_rdy=1 -> RRESP, else stay.
REQ-021 In RRESP: ret_valid&&ret_last -> capture ret_data into rdata, go DONE; ret_valid without ret_last is discarded.
REQ-022 In WREQ: wr_req=1, wr_addr=latched addr, wr_type={1'b0,size}, wr_wstrb=latched wstrb, wr_data={96'b0,latched wdata}; wr_rdy=1 -> DONE.
REQ-023 In DONE: data_ok=1 for exactly one cycle, then IDLE unconditionally.
REQ-024 Latency: read = 1 (accept) + rd_rdy wait + return wait + 1 (DONE); write with wr_rdy already high: data_ok 2 cycles after addr_ok.
REQ-025 rd_req and wr_req SHALL never be asserted together, nor outside RREQ/WREQ respectively.
REQ-026 rdata SHALL hold its value until the next read capture; writes do not modify it.
REQ-027 Bus request outputs SHALL be stable (registered sources) while req is held and rdy is low.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE; data_ok, rd_req, wr_req = 0; rdata and latched fields = 0.
REQ-029 rst mid-transaction SHALL abandon the access without emitting data_ok; a late ret_valid after reset SHALL be ignored in IDLE.

Structure
REQ-030 State encodings and type codes (BYTE=3'b000, HALF=3'b001, WORD=3'b010) SHALL live in the shared define header.
REQ-031 Single flat module; no sub-module; sits behind mem_cache_prep uncache_valid and feeds cache_select uncache inputs.

Verification
REQ-032 Read: valid,op=0,size=10,addr=0x1faf0004; rd_rdy=1; ret_valid/ret_last=1, ret_data=0xDEADBEEF 2 cycles later -> rd_req 1 cycle, data_ok pulse, rdata=0xDEADBEEF.
REQ-033 Write: op=1,size=00,addr=0x1faf0003,wstrb=4'b1000,wdata=0x55000000; wr_rdy held low 3 cycles -> wr_req held 4 cycles, fields stable, data_ok one cycle after handshake.
REQ-034 Back-to-back: second valid during RRESP -> addr_ok=0 until IDLE, then accepted; two data_ok pulses, correct order.
REQ-035 Multi-beat return: ret_valid with ret_last=0 (0x11111111) then ret_last=1 (0x22222222) -> rdata=0x22222222.
REQ-036 Reset in RRESP, then ret_valid -> no data_ok, state IDLE, rdata=0.
REQ-037 Assertion: rd_req&&wr_req never 1; data_ok never two consecutive cycles.
